erro_scan_ctrl: RTL and testbench

ERRO_SCAN_CTRL -- requirements
Module: erro_scan_ctrl

---
 rtl/erro_scan_ctrl.sv | 160 ++++++++++++++++
 tb/tb_erro_scan_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/erro_scan_ctrl.sv
// erro_scan_ctrl: scan-slot sequencer and error latch for a multiplexed error display.
//
// A prescaler divides clk0 by DIV and advances a three-slot digit select (000 -> 001 -> 010),
// pulsing tick on every advance. Two asynchronous error flags (sensor inconsistency and
// data-value error) are synchronized, debounced over DEB cycles and latched sticky until
// cleared.
//
// Parameters:
//   DIV      clk0 cycles per scan slot (2 .. 2^20)
//   DEB      cycles a synchronized input must hold before it is accepted (1 .. 255)
//
// Ports:
//   clk0     in   system clock, rising-edge active
//   rst      in   asynchronous active-high reset
//   enable   in   scan enable; low freezes prescaler and select
//   v_raw    in   raw sensor-inconsistency flag (asynchronous)
//   d_raw    in   raw data-value error flag (asynchronous)
//   clear    in   one-cycle request to drop latched errors whose input has gone away
//   select   out  digit-scan slot, registered
//   V_sense  out  latched debounced sensor error
//   D_valor  out  latched debounced data error
//   erro_any out  V_sense | D_valor, one cycle later
//   tick     out  one-cycle pulse on each select advance
module erro_scan_ctrl #(
  parameter int unsigned DIV = 50000,
  parameter int unsigned DEB = 16
) (
  input  logic       clk0,
  input  logic       rst,
  input  logic       enable,
  input  logic       v_raw,
  input  logic       d_raw,
  input  logic       clear,
  output logic [2:0] select,
  output logic       V_sense,
  output logic       D_valor,
  output logic       erro_any,
  output logic       tick
);

  localparam int unsigned CntW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DIV - 1);
  // Counter value on which one more differing cycle reaches DEB.
  localparam logic [7:0] DebMax = 8'(DEB - 1);

  typedef enum logic [2:0] {
    SelSlot0 = 3'b000,
    SelSlot1 = 3'b001,
    SelSlot2 = 3'b010
  } sel_e;

  sel_e            sel_q, sel_d;
  logic [CntW-1:0] presc_q, presc_d;
  logic            tick_q, tick_d;
  logic            wrap;

  // Channel 0 is the sensor (V) path, channel 1 the data (D) path.
  logic [1:0]      raw;
  logic [1:0]      sync1_q, sync2_q;
  logic [1:0]      acc_q, acc_d;
  logic [1:0][7:0] deb_cnt_q, deb_cnt_d;
  logic [1:0]      flag_q, flag_d;
  logic            any_q, any_d;

  assign raw  = {d_raw, v_raw};
  assign wrap = enable && (presc_q == CntMax);

  // Prescaler and tick.
  always_comb begin
    presc_d = presc_q;
    tick_d  = 1'b0;
    if (enable) begin
      if (presc_q == CntMax) begin
        presc_d = '0;
        tick_d  = 1'b1;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
  end

  // Select FSM: state register.
  always_ff @(posedge clk0 or posedge rst) begin
    if (rst) begin
      sel_q <= SelSlot0;
    end else begin
      sel_q <= sel_d;
    end
  end

  // Select FSM: next state. Unused encodings recover to slot 0 on the next edge.
  always_comb begin
    sel_d = sel_q;
    case (sel_q)
      SelSlot0: if (wrap) sel_d = SelSlot1;
      SelSlot1: if (wrap) sel_d = SelSlot2;
      SelSlot2: if (wrap) sel_d = SelSlot0;
      default:  sel_d = SelSlot0;
    endcase
  end

  // Select FSM: output.
  always_comb begin
    select = sel_q;
  end

  // Debouncers: count cycles the synchronized value disagrees with the accepted value and
  // accept it on the edge where that count would reach DEB.
  always_comb begin
    acc_d     = acc_q;
    deb_cnt_d = deb_cnt_q;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] != acc_q[i]) begin
        if (deb_cnt_q[i] == DebMax) begin
          acc_d[i]     = sync2_q[i];
          deb_cnt_d[i] = '0;
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + 8'd1;
        end
      end else begin
        deb_cnt_d[i] = '0;
      end
    end
  end

  // Sticky flags: an active accepted input sets (and beats clear); clear only drops a flag
  // whose accepted input is already back to 0.
  always_comb begin
    flag_d = acc_q | (flag_q & ~{2{clear}});
    any_d  = |flag_q;
  end

  always_ff @(posedge clk0 or posedge rst) begin
    if (rst) begin
      presc_q   <= '0;
      tick_q    <= 1'b0;
      sync1_q   <= '0;
      sync2_q   <= '0;
      acc_q     <= '0;
      deb_cnt_q <= '0;
      flag_q    <= '0;
      any_q     <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      tick_q    <= tick_d;
      sync1_q   <= raw;
      sync2_q   <= sync1_q;
      acc_q     <= acc_d;
      deb_cnt_q <= deb_cnt_d;
      flag_q    <= flag_d;
      any_q     <= any_d;
    end
  end

  assign tick     = tick_q;
  assign V_sense  = flag_q[0];
  assign D_valor  = flag_q[1];
  assign erro_any = any_q;

endmodule

// File: tb/tb_erro_scan_ctrl.sv
module tb_erro_scan_ctrl;

  localparam int unsigned DIV = 4;
  localparam int unsigned DEB = 3;

  logic       clk0 = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       v_raw = 1'b0;
  logic       d_raw = 1'b0;
  logic       clear = 1'b0;
  logic [2:0] select;
  logic       V_sense, D_valor, erro_any, tick;

  int n_cmp = 0;
  int n_fail = 0;

  erro_scan_ctrl #(
    .DIV(DIV),
    .DEB(DEB)
  ) dut (
    .clk0    (clk0),
    .rst     (rst),
    .enable  (enable),
    .v_raw   (v_raw),
    .d_raw   (d_raw),
    .clear   (clear),
    .select  (select),
    .V_sense (V_sense),
    .D_valor (D_valor),
    .erro_any(erro_any),
    .tick    (tick)
  );

  always #5 clk0 = ~clk0;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check3(input string name, input logic [2:0] act, input logic [2:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk0);
    #1;
  endtask

  // Leaves the bench 1 time unit after a rising edge with reset released.
  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // Reference model: counts and slots as plain integers, sync as a two-deep sample history.
  int m_presc, m_slot, m_run[2];
  bit m_tick, m_any;
  bit m_s1[2], m_s2[2], m_acc[2], m_flag[2];

  task automatic model_reset();
    m_presc = 0;
    m_slot  = 0;
    m_tick  = 0;
    m_any   = 0;
    for (int i = 0; i < 2; i++) begin
      m_run[i]  = 0;
      m_s1[i]   = 0;
      m_s2[i]   = 0;
      m_acc[i]  = 0;
      m_flag[i] = 0;
    end
  endtask

  // Advance the model by one edge using the inputs that were held across it.
  task automatic model_step();
    bit raw[2];
    raw[0] = v_raw;
    raw[1] = d_raw;
    m_any = m_flag[0] | m_flag[1];
    for (int i = 0; i < 2; i++) begin
      if (m_acc[i]) m_flag[i] = 1;
      else if (clear) m_flag[i] = 0;
    end
    for (int i = 0; i < 2; i++) begin
      if (m_s2[i] != m_acc[i]) begin
        m_run[i]++;
        if (m_run[i] == DEB) begin
          m_acc[i] = m_s2[i];
          m_run[i] = 0;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    for (int i = 0; i < 2; i++) begin
      m_s2[i] = m_s1[i];
      m_s1[i] = raw[i];
    end
    m_tick = 0;
    if (enable) begin
      if (m_presc == DIV - 1) begin
        m_presc = 0;
        m_tick  = 1;
        m_slot  = (m_slot + 1) % 3;
      end else begin
        m_presc++;
      end
    end
  endtask

  typedef struct {
    logic       en, v, d, clr;
    logic [2:0] sel;
    logic       tk, vs, dv, any;
  } vec_t;

  vec_t tbl[12];

  initial begin
    // Row k: inputs held across edge k after reset release, outputs expected after it.
    tbl[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 3'd2, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 3'd2, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 3'd2, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 3'd2, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b1};

    // Reset state.
    #2;
    check3("reset select", select, 3'd0);
    check1("reset tick", tick, 1'b0);
    check1("reset V_sense", V_sense, 1'b0);
    check1("reset D_valor", D_valor, 1'b0);
    check1("reset erro_any", erro_any, 1'b0);
    do_reset();

    // Table: scan sequence, short d pulse rejected, v debounce latency, sticky under clear.
    for (int i = 0; i < 12; i++) begin
      enable = tbl[i].en;
      v_raw  = tbl[i].v;
      d_raw  = tbl[i].d;
      clear  = tbl[i].clr;
      step();
      check3($sformatf("tbl[%0d] select", i), select, tbl[i].sel);
      check1($sformatf("tbl[%0d] tick", i), tick, tbl[i].tk);
      check1($sformatf("tbl[%0d] V_sense", i), V_sense, tbl[i].vs);
      check1($sformatf("tbl[%0d] D_valor", i), D_valor, tbl[i].dv);
      check1($sformatf("tbl[%0d] erro_any", i), erro_any, tbl[i].any);
    end

    // v drops and is debounced low; flag stays until clear, then drops on the next edge.
    v_raw = 1'b0;
    clear = 1'b0;
    for (int i = 0; i < 6; i++) step();
    check1("sticky V after v low", V_sense, 1'b1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    check1("clear drops V", V_sense, 1'b0);
    step();
    check1("clear drops erro_any", erro_any, 1'b0);

    // Enable freeze: two counts, five frozen cycles, then resume without skip or duplicate.
    enable = 1'b1;
    do_reset();
    step();
    step();
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check1("frozen tick", tick, 1'b0);
      check3("frozen select", select, 3'd0);
    end
    enable = 1'b1;
    step();
    check1("resume no early tick", tick, 1'b0);
    step();
    check1("resume tick", tick, 1'b1);
    check3("resume select 001", select, 3'd1);
    for (int i = 0; i < 3; i++) step();
    check1("resume gap tick", tick, 1'b0);
    step();
    check1("resume second tick", tick, 1'b1);
    check3("resume select 010", select, 3'd2);

    // Both raw inputs rise together; clear is high as the accepted values rise.
    do_reset();
    v_raw = 1'b1;
    d_raw = 1'b1;
    for (int i = 0; i < 4; i++) step();
    check1("both early V", V_sense, 1'b0);
    clear = 1'b1;
    step();
    check1("both early D", D_valor, 1'b0);
    step();
    clear = 1'b0;
    check1("set wins D_valor", D_valor, 1'b1);
    check1("simultaneous V_sense", V_sense, 1'b1);

    // Asynchronous reset between edges with select at 010 and flags latched.
    step();
    step();
    check3("pre-reset select", select, 3'd2);
    check1("pre-reset V", V_sense, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check3("async rst select", select, 3'd0);
    check1("async rst V_sense", V_sense, 1'b0);
    check1("async rst D_valor", D_valor, 1'b0);
    check1("async rst erro_any", erro_any, 1'b0);
    check1("async rst tick", tick, 1'b0);
    v_raw = 1'b0;
    d_raw = 1'b0;
    step();
    rst = 1'b0;
    for (int i = 0; i < DIV - 1; i++) begin
      step();
      check1("post-reset no tick", tick, 1'b0);
    end
    step();
    check1("post-reset first tick", tick, 1'b1);
    check3("post-reset select", select, 3'd1);

    // Randomized run against the reference model, with a reset in the middle.
    do_reset();
    model_reset();
    for (int c = 0; c < 600; c++) begin
      if (c == 300) begin
        do_reset();
        model_reset();
      end
      enable = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 5) == 0) v_raw = ~v_raw;
      if ($urandom_range(0, 5) == 0) d_raw = ~d_raw;
      clear = ($urandom_range(0, 7) == 0);
      step();
      model_step();
      check3("rnd select", select, 3'(m_slot));
      check1("rnd tick", tick, m_tick);
      check1("rnd V_sense", V_sense, m_flag[0]);
      check1("rnd D_valor", D_valor, m_flag[1]);
      check1("rnd erro_any", erro_any, m_any);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
